// File: rtl/shift_deserializer.sv
// ---------------------------------------------------------------------------
// shift_deserializer
//   Receive end of a serial shift path. Bits arriving on sin (qualified by
//   sin_valid) are collected into a WIDTH-bit word, MSB-first or LSB-first
//   as chosen by dir at the first bit of each word. Each completed word is
//   handed to a one-deep valid/ready output register. A completed word that
//   finds the register still occupied is dropped, and the sticky overrun
//   flag is set.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   clr         in   1      synchronous clear of bit counter and overrun
//   sin         in   1      serial data bit
//   sin_valid   in   1      sample sin on this edge
//   dir         in   1      0 = MSB-first, 1 = LSB-first (taken at bit 0)
//   dout        out  WIDTH  completed parallel word
//   dout_valid  out  1      dout holds an unconsumed word
//   dout_ready  in   1      consumer accepts dout when dout_valid is high
//   overrun     out  1      sticky: a completed word was dropped
//   bit_cnt     out  CW     bits collected in the current word
// ---------------------------------------------------------------------------
module shift_deserializer #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_dir_l;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;

    logic             w_sample;
    logic             w_dir_eff;
    logic [WIDTH-1:0] w_shifted;
    logic             w_complete;
    logic             w_accept;

    // clr takes priority over a simultaneous bit: that bit is not sampled.
    assign w_sample = sin_valid & ~clr;

    // dir only matters on the first bit; later bits follow the latched value
    // so a mid-word change cannot scramble the word being assembled.
    assign w_dir_eff = (r_cnt == '0) ? dir : r_dir_l;

    always_comb begin
        w_shifted = r_sr;
        if (w_dir_eff) begin
            w_shifted = {sin, r_sr[WIDTH-1:1]};
        end else begin
            w_shifted = {r_sr[WIDTH-2:0], sin};
        end
    end

    assign w_complete = w_sample & (r_cnt == LAST_BIT);
    assign w_accept   = r_dout_valid & dout_ready;

    // Shift register, bit counter and direction latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_dir_l <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (sin_valid) begin
            r_sr <= w_shifted;
            if (r_cnt == '0) begin
                r_dir_l <= dir;
            end
            if (r_cnt == LAST_BIT) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // One-deep output register. Accepting and completing on the same edge
    // refills it directly, so a steady stream runs without bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_complete && (!r_dout_valid || w_accept)) begin
                r_dout       <= w_shifted;
                r_dout_valid <= 1'b1;
            end else if (w_accept) begin
                r_dout_valid <= 1'b0;
            end

            if (clr) begin
                r_overrun <= 1'b0;
            end else if (w_complete && r_dout_valid && !dout_ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;
    assign bit_cnt    = r_cnt;

endmodule

// File: tb/tb_shift_deserializer.sv
module tb_shift_deserializer;

    localparam int WIDTH = 4;
    localparam int CW    = 3;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             sin;
    logic             sin_valid;
    logic             dir;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;

    int n_checks;
    int n_fail;

    shift_deserializer #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .dir        (dir),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .bit_cnt    (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        clr        = 1'b0;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        dir        = 1'b0;
        dout_ready = 1'b0;
        tick();
        tick();

        check("rst_dout",    32'(dout),       32'h0);
        check("rst_valid",   32'(dout_valid), 32'h0);
        check("rst_overrun", 32'(overrun),    32'h0);
        check("rst_cnt",     32'(bit_cnt),    32'h0);
        rst = 1'b0;
        tick();

        // 1: MSB-first, consecutive bits 1,0,0,1
        dir = 1'b0;
        send(1'b1); send(1'b0); send(1'b0);
        check("t1_cnt3",   32'(bit_cnt),    32'd3);
        check("t1_novld",  32'(dout_valid), 32'h0);
        send(1'b1);
        check("t1_dout",   32'(dout),       32'h9);
        check("t1_valid",  32'(dout_valid), 32'h1);
        check("t1_cnt0",   32'(bit_cnt),    32'd0);

        // consume: valid drops, dout keeps last value
        drain();
        check("acc_valid", 32'(dout_valid), 32'h0);
        check("acc_dout",  32'(dout),       32'h9);

        // 2: LSB-first, bits 1,1,0,1 with 2-cycle gaps
        dir = 1'b1;
        send(1'b1); check("t2_cnt1", 32'(bit_cnt), 32'd1);
        tick(); tick(); check("t2_hold1", 32'(bit_cnt), 32'd1);
        send(1'b1); check("t2_cnt2", 32'(bit_cnt), 32'd2);
        tick(); tick(); check("t2_hold2", 32'(bit_cnt), 32'd2);
        send(1'b0); check("t2_cnt3", 32'(bit_cnt), 32'd3);
        tick(); tick();
        check("t2_hold3",  32'(bit_cnt),    32'd3);
        check("t2_novld",  32'(dout_valid), 32'h0);
        send(1'b1);
        check("t2_cnt0",   32'(bit_cnt),    32'd0);
        check("t2_dout",   32'(dout),       32'hB);
        check("t2_valid",  32'(dout_valid), 32'h1);

        // 3: overrun while held, then clr
        dir = 1'b0;
        send(1'b0); send(1'b0); send(1'b0);
        check("t3_noovr",  32'(overrun),    32'h0);
        send(1'b0);
        check("t3_dout",   32'(dout),       32'hB);
        check("t3_ovr",    32'(overrun),    32'h1);
        tick(); tick();
        check("t3_sticky", 32'(overrun),    32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3_clr_ovr", 32'(overrun),    32'h0);
        check("t3_clr_vld", 32'(dout_valid), 32'h1);
        check("t3_clr_dout", 32'(dout),      32'hB);

        // 4: accept on the same edge as completion of 0110
        dir = 1'b0;
        send(1'b0); send(1'b1); send(1'b1);
        dout_ready = 1'b1;
        send(1'b0);
        dout_ready = 1'b0;
        check("t4_dout",   32'(dout),       32'h6);
        check("t4_valid",  32'(dout_valid), 32'h1);
        check("t4_ovr",    32'(overrun),    32'h0);

        // 5: reset mid-word, then 1111
        drain();
        send(1'b1); send(1'b0);
        check("t5_cnt2",   32'(bit_cnt),    32'd2);
        rst = 1'b1;
        tick();
        check("t5_rdout",  32'(dout),       32'h0);
        check("t5_rvld",   32'(dout_valid), 32'h0);
        check("t5_rcnt",   32'(bit_cnt),    32'd0);
        check("t5_rovr",   32'(overrun),    32'h0);
        rst = 1'b0;
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        check("t5_dout",   32'(dout),       32'hF);
        check("t5_valid",  32'(dout_valid), 32'h1);

        // 6: dir changes after bit 0 -> word stays MSB-first (1011)
        drain();
        dir = 1'b0;
        send(1'b1);
        dir = 1'b1;
        send(1'b0); send(1'b1); send(1'b1);
        check("t6_dout_a", 32'(dout),       32'hB);
        // next word uses the new direction: 1,0,0,0 LSB-first -> 0001
        drain();
        send(1'b1); send(1'b0); send(1'b0); send(1'b0);
        check("t6_dout_b", 32'(dout),       32'h1);
        check("t6_valid",  32'(dout_valid), 32'h1);

        // clr with a simultaneous bit at the last position: no completion
        dir = 1'b0;
        send(1'b1); send(1'b1); send(1'b1);
        clr       = 1'b1;
        sin       = 1'b1;
        sin_valid = 1'b1;
        tick();
        clr       = 1'b0;
        sin_valid = 1'b0;
        check("clr_cnt",   32'(bit_cnt),    32'd0);
        check("clr_dout",  32'(dout),       32'h1);
        check("clr_ovr",   32'(overrun),    32'h0);
        // the following bit is bit 0 of a fresh word
        send(1'b1);
        check("clr_next",  32'(bit_cnt),    32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
